// File: rtl/cells_pkg.sv
// Shared definitions for the primitive register cells: mode encoding and width bounds.
package cells_pkg;

   localparam int SREG_MIN_W = 2;
   localparam int SREG_MAX_W = 32;

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_ROL   = 3'b100,
      MODE_ROR   = 3'b101,
      MODE_CNTUP = 3'b110,
      MODE_CNTDN = 3'b111
   } sreg_mode_t;

endpackage

// File: rtl/sreg_bank_cell_if.sv
// Bus bundle for sreg_bank_cell; par/par_err exist only with SREG_BANK_PARITY_EN.
interface sreg_bank_cell_if
   import cells_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic              en;
   sreg_mode_t        mode;
   logic [WIDTH-1:0]  d;
   logic              si;
   logic [WIDTH-1:0]  q;
   logic [WIDTH-1:0]  notq;
   logic              so_msb;
   logic              so_lsb;
   logic              wrap;
`ifdef SREG_BANK_PARITY_EN
   logic              par;
   logic              par_err;
`endif

   modport master (
      output en, mode, d, si,
`ifdef SREG_BANK_PARITY_EN
      input  par, par_err,
`endif
      input  q, notq, so_msb, so_lsb, wrap
   );

   modport slave (
      input  en, mode, d, si,
`ifdef SREG_BANK_PARITY_EN
      output par, par_err,
`endif
      output q, notq, so_msb, so_lsb, wrap
   );
endinterface

// File: rtl/sreg_next_cell.sv
// Combinational next-state for the universal register: next_q and wrap_next from q/d/si/mode.
(* keep_hierarchy = "yes" *)
module sreg_next_cell
   import cells_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             si,
   input  sreg_mode_t       mode,
   output logic [WIDTH-1:0] next_q,
   output logic             wrap_next
);

   always_comb begin
      next_q    = q;
      wrap_next = 1'b0;
      case (mode)
         MODE_HOLD:  next_q = q;
         MODE_LOAD:  next_q = d;
         MODE_SHL:   next_q = {q[WIDTH-2:0], si};
         MODE_SHR:   next_q = {si, q[WIDTH-1:1]};
         MODE_ROL:   next_q = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:   next_q = {q[0], q[WIDTH-1:1]};
         MODE_CNTUP: begin
            next_q    = q + 1'b1;
            wrap_next = &q;
         end
         MODE_CNTDN: begin
            next_q    = q - 1'b1;
            wrap_next = ~|q;
         end
         default:    next_q = q;
      endcase
   end

endmodule

// File: rtl/sreg_bank_cell.sv
// WIDTH-bit universal register cell (hold/load/shift/rotate/count) with wrap pulse.
// Optional registered even parity with SREG_BANK_PARITY_EN.
module sreg_bank_cell
   import cells_pkg::*;
#(
   parameter int                      WIDTH     = 8,
   parameter logic [SREG_MAX_W-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             r,
   sreg_bank_cell_if.slave  bus
);

   localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

   if (WIDTH < SREG_MIN_W || WIDTH > SREG_MAX_W) begin : g_bad_width
      $error("sreg_bank_cell: WIDTH out of range");
   end

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] next_q;
   logic             wrap_r;
   logic             wrap_next;

   sreg_next_cell #(.WIDTH(WIDTH)) u_next (
      .q         (q_r),
      .d         (bus.d),
      .si        (bus.si),
      .mode      (bus.mode),
      .next_q    (next_q),
      .wrap_next (wrap_next)
   );

   // Reset beats enable; a disabled cycle still clears wrap so the pulse is one cycle.
   always_ff @(posedge clk) begin
      if (r) begin
         q_r    <= RST_Q;
         wrap_r <= 1'b0;
      end else if (bus.en) begin
         q_r    <= next_q;
         wrap_r <= wrap_next;
      end else begin
         wrap_r <= 1'b0;
      end
   end

   assign bus.q      = q_r;
   assign bus.notq   = ~q_r;
   assign bus.so_msb = q_r[WIDTH-1];
   assign bus.so_lsb = q_r[0];
   assign bus.wrap   = wrap_r;

`ifdef SREG_BANK_PARITY_EN
   logic par_r;

   always_ff @(posedge clk) begin
      if (r) begin
         par_r <= ^RST_Q;
      end else if (bus.en) begin
         par_r <= ^next_q;
      end
   end

   assign bus.par     = par_r;
   assign bus.par_err = par_r ^ (^q_r);
`endif

endmodule

// File: tb/tb_sreg_bank_cell.sv
// Self-checking bench for sreg_bank_cell (WIDTH=8, RESET_VAL=8'hA5); directed tests plus random vs. model.
module tb_sreg_bank_cell;
   import cells_pkg::*;

   logic clk = 1'b0;
   logic r   = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_q    = 0;
   bit   exp_wrap = 1'b0;

   sreg_bank_cell_if #(.WIDTH(8)) bus ();

   sreg_bank_cell #(.WIDTH(8), .RESET_VAL(32'h0000_00A5)) dut (
      .clk (clk),
      .r   (r),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: register value as an integer 0..255, operations as plain arithmetic.
   function automatic void model(input bit rr, input bit e, input int m, input int dd, input bit s);
      int nq;
      bit w;
      nq = exp_q;
      w  = 1'b0;
      if (rr) nq = 165;
      else if (e) begin
         case (m)
            1: nq = dd;
            2: nq = (exp_q * 2 + s) % 256;
            3: nq = exp_q / 2 + s * 128;
            4: nq = (exp_q * 2) % 256 + exp_q / 128;
            5: nq = exp_q / 2 + (exp_q % 2) * 128;
            6: begin w = (exp_q == 255); nq = (exp_q + 1) % 256; end
            7: begin w = (exp_q == 0);   nq = (exp_q + 255) % 256; end
            default: nq = exp_q;
         endcase
      end
      exp_q    = nq;
      exp_wrap = w;
   endfunction

   task automatic step(input bit rr, input bit e, input int m, input logic [7:0] dd, input bit s);
      r        = rr;
      bus.en   = e;
      bus.mode = sreg_mode_t'(m[2:0]);
      bus.d    = dd;
      bus.si   = s;
      model(rr, e, m, int'(dd), s);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1, 1, 6, 8'h00, 0);
      n_checks++; if (bus.q !== 8'hA5) begin n_fail++; $display("FAIL reset_q got=%h exp=a5", bus.q); end
      n_checks++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
      n_checks++; if (bus.notq !== 8'h5A) begin n_fail++; $display("FAIL reset_notq got=%h exp=5a", bus.notq); end
      n_checks++; if (bus.so_msb !== 1'b1 || bus.so_lsb !== 1'b1) begin
         n_fail++; $display("FAIL reset_serial got=%b%b exp=11", bus.so_msb, bus.so_lsb); end
   endtask

   task automatic test_shift();
      logic [7:0] exp_tab [3] = '{8'h02, 8'h05, 8'h0B};
      bit         si_tab  [3] = '{1'b0, 1'b1, 1'b1};
      step(0, 1, 1, 8'h81, 0);
      n_checks++; if (bus.q !== 8'h81) begin n_fail++; $display("FAIL load got=%h exp=81", bus.q); end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 2, 8'h00, si_tab[i]);
         n_checks++; if (bus.q !== exp_tab[i]) begin n_fail++; $display("FAIL shl_%0d got=%h exp=%h", i, bus.q, exp_tab[i]); end
         if (i == 0) begin
            n_checks++; if (bus.so_msb !== 1'b0) begin n_fail++; $display("FAIL shl_so_msb got=%b exp=0", bus.so_msb); end
         end
      end
      step(0, 1, 3, 8'h00, 1);
      n_checks++; if (bus.q !== 8'h85) begin n_fail++; $display("FAIL shr got=%h exp=85", bus.q); end
   endtask

   task automatic test_rotate();
      logic [7:0] exp_tab [4] = '{8'hC0, 8'h60, 8'hC0, 8'h81};
      step(0, 1, 1, 8'h81, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, (i < 2) ? 5 : 4, 8'h00, 0);
         n_checks++; if (bus.q !== exp_tab[i]) begin n_fail++; $display("FAIL rot_%0d got=%h exp=%h", i, bus.q, exp_tab[i]); end
      end
   endtask

   task automatic test_count();
      logic [7:0] exp_tab [3] = '{8'hFF, 8'h00, 8'h01};
      bit         w_tab   [3] = '{1'b0, 1'b1, 1'b0};
      step(0, 1, 1, 8'hFE, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 6, 8'h00, 0);
         n_checks++; if (bus.q !== exp_tab[i] || bus.wrap !== w_tab[i]) begin
            n_fail++; $display("FAIL cntup_%0d got=%h/%b exp=%h/%b", i, bus.q, bus.wrap, exp_tab[i], w_tab[i]); end
      end
      step(0, 1, 1, 8'h00, 0);
      n_checks++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL load_wrap got=%b exp=0", bus.wrap); end
      step(0, 1, 7, 8'h00, 0);
      n_checks++; if (bus.q !== 8'hFF || bus.wrap !== 1'b1) begin
         n_fail++; $display("FAIL cntdn_wrap got=%h/%b exp=ff/1", bus.q, bus.wrap); end
      step(0, 1, 0, 8'h00, 0);
      n_checks++; if (bus.q !== 8'hFF || bus.wrap !== 1'b0) begin
         n_fail++; $display("FAIL wrap_pulse got=%h/%b exp=ff/0", bus.q, bus.wrap); end
   endtask

   task automatic test_enable_reset();
      logic [7:0] exp_tab [3] = '{8'h11, 8'h11, 8'h12};
      bit         en_tab  [3] = '{1'b1, 1'b0, 1'b1};
      step(0, 1, 1, 8'h10, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, en_tab[i], 6, 8'h00, 0);
         n_checks++; if (bus.q !== exp_tab[i]) begin n_fail++; $display("FAIL enable_%0d got=%h exp=%h", i, bus.q, exp_tab[i]); end
      end
      step(0, 1, 1, 8'hFF, 0);
      step(1, 1, 6, 8'h00, 0);
      n_checks++; if (bus.q !== 8'hA5 || bus.wrap !== 1'b0) begin
         n_fail++; $display("FAIL reset_midcount got=%h/%b exp=a5/0", bus.q, bus.wrap); end
      step(0, 0, 6, 8'h00, 0);
      n_checks++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL disabled_wrap got=%b exp=0", bus.wrap); end
   endtask

   task automatic test_random();
      int errs = 0;
      step(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 1000; i++) begin
         if (i == 500) step(1, 1, 7, 8'h00, 0);
         else step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                   int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
         n_checks++;
         if (bus.q !== 8'(exp_q) || bus.wrap !== exp_wrap || bus.notq !== ~8'(exp_q)
             || bus.so_msb !== exp_q[7] || bus.so_lsb !== exp_q[0]) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL random_%0d got=%h/%b exp=%h/%b", i, bus.q, bus.wrap, 8'(exp_q), exp_wrap);
         end
`ifdef SREG_BANK_PARITY_EN
         n_checks++;
         if (bus.par !== ^(8'(exp_q)) || bus.par_err !== 1'b0) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL parity_%0d got=%b/%b exp=%b/0", i, bus.par, bus.par_err, ^(8'(exp_q)));
         end
`endif
      end
   endtask

   initial begin
      bus.en   = 1'b0;
      bus.mode = MODE_HOLD;
      bus.d    = '0;
      bus.si   = 1'b0;
      test_reset();
      test_shift();
      test_rotate();
      test_count();
      test_enable_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
